// File: rtl/div_if.sv
// div_if: handshake and operand/result bundle between a requester and seq_div.
//   start       - request to begin a division (master -> slave)
//   dividend    - unsigned dividend (master -> slave)
//   divisor     - unsigned divisor (master -> slave)
//   quotient    - registered quotient of the last completed division (slave -> master)
//   remainder   - registered remainder of the last completed division (slave -> master)
//   busy        - division in progress (slave -> master)
//   done        - one-cycle result-valid pulse (slave -> master)
//   div_by_zero - results came from a zero-divisor request (slave -> master)
interface div_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    modport master (output start, dividend, divisor,
                    input  quotient, remainder, busy, done, div_by_zero);
    modport slave  (input  start, dividend, divisor,
                    output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring unsigned divider, one quotient bit per clock.
//   clk   - clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - div_if slave: start/dividend/divisor in; quotient/remainder/busy/done/div_by_zero out
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   trial;
    logic             nb;
    // a_q holds the dividend and fills with quotient bits from the bottom as it shifts out,
    // so after WIDTH steps it contains the quotient. Since partial < divisor always,
    // bit WIDTH of the (WIDTH+1)-bit trial is exactly the borrow.
    always_comb begin
        sh      = {p_q, a_q[WIDTH-1]};
        trial   = sh - {1'b0, b_q};
        nb      = ~trial[WIDTH];
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_d   = bus.dividend;
                b_d   = bus.divisor;
                p_d   = '0;
                cnt_d = '0;
                if (bus.divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = bus.dividend;
                    dz_d    = 1'b1;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = {a_q[WIDTH-2:0], nb};
                p_d   = nb ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quo_d   = a_d;
                    rem_d   = p_d;
                    dz_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == CALC;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule
